// File: rtl/ram_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ram_init_sequencer
//  Description : Write-side front end for the configurable RAM. After reset it
//                walks every entry through all write ports in parallel with the
//                reset pattern and holds ramReady_o low until the walk is done;
//                afterwards functional writes pass straight through.
//                Optional feature macro: RAM_PART_REINIT_EN -- re-initialises a
//                partition whenever it comes out of power gating.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_init_sequencer #(
    parameter int DEPTH        = 32,
    parameter int INDEX        = 5,
    parameter int WIDTH        = 32,
    parameter int NUM_WR_PORTS = 4,
    parameter int NUM_PARTS    = 4,
    parameter int RESET_SEQ    = 0,
    parameter int SEQ_START    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PARTS-1:0]          partitionGated_i,
    input  logic [NUM_WR_PORTS-1:0]       wrEn_i,
    input  logic [NUM_WR_PORTS*INDEX-1:0] addrWr_i,
    input  logic [NUM_WR_PORTS*WIDTH-1:0] dataWr_i,
    output logic [NUM_WR_PORTS-1:0]       wrEnRam_o,
    output logic [NUM_WR_PORTS*INDEX-1:0] addrWrRam_o,
    output logic [NUM_WR_PORTS*WIDTH-1:0] dataWrRam_o,
    output logic                          ramReady_o,
    output logic                          droppedWr_o
);

    // Number of walk cycles for the whole RAM and for one partition.
    localparam int c_INIT_CYCLES = (DEPTH + NUM_WR_PORTS - 1) / NUM_WR_PORTS;
    localparam int c_PART_DEPTH  = DEPTH / NUM_PARTS;
    localparam int c_PART_CYCLES = (c_PART_DEPTH + NUM_WR_PORTS - 1) / NUM_WR_PORTS;
    // One spare bit keeps the counter wide enough for any walk length.
    localparam int c_CNT_W       = INDEX + 1;
    localparam int c_PART_W      = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_READY  = 2'd1
`ifdef RAM_PART_REINIT_EN
        ,
        S_REINIT = 2'd2
`endif
    } state_t;

    state_t                          r_state;
    logic [c_CNT_W-1:0]              r_cnt;
    logic                            r_ramReady;

    // Region currently being walked: start index and length in entries.
    logic [INDEX-1:0]                w_walkBase;
    logic [31:0]                     w_walkLimit;
    // Suppresses walk writes (partition re-gated during its own re-init).
    logic                            w_walkHold;
    logic [NUM_WR_PORTS-1:0]         w_walkEn;
    logic [NUM_WR_PORTS*INDEX-1:0]   w_walkAddr;
    logic [NUM_WR_PORTS*WIDTH-1:0]   w_walkData;

`ifdef RAM_PART_REINIT_EN
    logic [NUM_PARTS-1:0]            r_gatedPrev;
    logic [NUM_PARTS-1:0]            r_pending;
    logic [c_PART_W-1:0]             r_part;
    logic [NUM_PARTS-1:0]            w_ungated;
    logic [c_PART_W-1:0]             w_nextPart;
    logic [NUM_PARTS-1:0]            w_nextMask;
    logic                            w_abort;

    // Lowest set bit of a partition mask; lower partitions are served first.
    function automatic logic [c_PART_W-1:0] lowestSet(input logic [NUM_PARTS-1:0] v);
        lowestSet = '0;
        for (int i = NUM_PARTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowestSet = c_PART_W'(i);
            end
        end
    endfunction

    assign w_ungated  = r_gatedPrev & ~partitionGated_i;
    assign w_nextPart = lowestSet(r_pending);
    assign w_nextMask = NUM_PARTS'(1) << w_nextPart;
    assign w_abort    = (r_state == S_REINIT) && partitionGated_i[r_part];
    assign w_walkHold = w_abort;

    // Remember last cycle's gating so that an ungate (1->0) can be detected.
    always_ff @(posedge clk) begin
        r_gatedPrev <= partitionGated_i;
    end

    // Re-init walks cover only the selected partition; INIT covers the RAM.
    always_comb begin
        w_walkBase  = '0;
        w_walkLimit = 32'(DEPTH);
        if (r_state == S_REINIT) begin
            w_walkBase  = INDEX'(32'(r_part) * 32'(c_PART_DEPTH));
            w_walkLimit = 32'(c_PART_DEPTH);
        end
    end
`else
    // Gating only matters for re-initialisation, which this build lacks.
    logic w_unusedGated;
    assign w_unusedGated = ^partitionGated_i;
    assign w_walkHold    = 1'b0;
    assign w_walkBase    = '0;
    assign w_walkLimit   = 32'(DEPTH);
`endif

    // Per-lane walk address/data: lane p handles entry cnt*NUM_WR_PORTS + p of
    // the region; lanes that run past the end of the region stay idle.
    for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : g_lane
        logic [31:0]      w_offset;
        logic [INDEX-1:0] w_laneAddr;

        assign w_offset   = 32'(r_cnt) * 32'(NUM_WR_PORTS) + 32'(p);
        assign w_laneAddr = w_walkBase + w_offset[INDEX-1:0];
        assign w_walkEn[p] = (w_offset < w_walkLimit) && !w_walkHold;
        assign w_walkAddr[p*INDEX +: INDEX] = w_laneAddr;

        if (RESET_SEQ != 0) begin : g_seqData
            assign w_walkData[p*WIDTH +: WIDTH] = WIDTH'(SEQ_START) + WIDTH'(w_laneAddr);
        end else begin : g_zeroData
            assign w_walkData[p*WIDTH +: WIDTH] = '0;
        end
    end

    // RAM port mux: pass-through when ready, walk writes otherwise; any
    // functional write arriving while not ready is discarded and flagged.
    always_comb begin
        wrEnRam_o   = '0;
        addrWrRam_o = w_walkAddr;
        dataWrRam_o = w_walkData;
        droppedWr_o = 1'b0;
        if (!reset) begin
            if (r_state == S_READY) begin
                wrEnRam_o   = wrEn_i;
                addrWrRam_o = addrWr_i;
                dataWrRam_o = dataWr_i;
            end else begin
                wrEnRam_o   = w_walkEn;
                droppedWr_o = |wrEn_i;
            end
        end
    end

    assign ramReady_o = r_ramReady;

    // Sequencer FSM: walk counter, ready flag and (optionally) the queue of
    // partitions waiting to be re-initialised.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_cnt      <= '0;
            r_ramReady <= 1'b0;
`ifdef RAM_PART_REINIT_EN
            r_pending  <= '0;
            r_part     <= '0;
`endif
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_cnt == c_CNT_W'(c_INIT_CYCLES - 1)) begin
                        r_state    <= S_READY;
                        r_ramReady <= 1'b1;
                        r_cnt      <= '0;
`ifdef RAM_PART_REINIT_EN
                        // Ungates seen during INIT are covered by the full walk.
                        r_pending  <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_READY: begin
`ifdef RAM_PART_REINIT_EN
                    if (r_pending != '0) begin
                        r_state    <= S_REINIT;
                        r_ramReady <= 1'b0;
                        r_cnt      <= '0;
                        r_part     <= w_nextPart;
                        r_pending  <= (r_pending & ~w_nextMask) | w_ungated;
                    end else begin
                        r_pending  <= r_pending | w_ungated;
                    end
`endif
                end
`ifdef RAM_PART_REINIT_EN
                S_REINIT: begin
                    if (w_abort || (r_cnt == c_CNT_W'(c_PART_CYCLES - 1))) begin
                        r_cnt <= '0;
                        if (r_pending != '0) begin
                            // Chain straight into the next waiting partition.
                            r_part    <= w_nextPart;
                            r_pending <= (r_pending & ~w_nextMask) | w_ungated;
                        end else begin
                            r_state    <= S_READY;
                            r_ramReady <= 1'b1;
                            r_pending  <= w_ungated;
                        end
                    end else begin
                        r_cnt     <= r_cnt + c_CNT_W'(1);
                        r_pending <= r_pending | w_ungated;
                    end
                end
`endif
                default: begin
                    r_state    <= S_INIT;
                    r_cnt      <= '0;
                    r_ramReady <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_init_sequencer
//  Description : Self-checking bench for ram_init_sequencer (DEPTH=32, 4 write
//                ports, 4 partitions, sequence data starting at 8). Follows
//                RAM_PART_REINIT_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_init_sequencer;

    localparam int DEPTH = 32;
    localparam int INDEX = 5;
    localparam int WIDTH = 32;
    localparam int NWP   = 4;
    localparam int NP    = 4;
    localparam int SEQ   = 8;
    localparam int PDEP  = DEPTH / NP;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NP-1:0]         gated;
    logic [NWP-1:0]        wrEn;
    logic [NWP*INDEX-1:0]  addrWr;
    logic [NWP*WIDTH-1:0]  dataWr;
    logic [NWP-1:0]        wrEnRam;
    logic [NWP*INDEX-1:0]  addrRam;
    logic [NWP*WIDTH-1:0]  dataRam;
    logic                  ready;
    logic                  dropped;

    int n_cmp = 0;
    int n_bad = 0;

    ram_init_sequencer #(
        .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_WR_PORTS(NWP),
        .NUM_PARTS(NP), .RESET_SEQ(1), .SEQ_START(SEQ)
    ) dut (
        .clk(clk), .reset(reset), .partitionGated_i(gated),
        .wrEn_i(wrEn), .addrWr_i(addrWr), .dataWr_i(dataWr),
        .wrEnRam_o(wrEnRam), .addrWrRam_o(addrRam), .dataWrRam_o(dataRam),
        .ramReady_o(ready), .droppedWr_o(dropped)
    );

    always #5 clk = ~clk;

    // Reference: the writes expected in walk cycle cyc over [base, base+size).
    function automatic void model_walk(input int cyc, input int base, input int size,
                                       output logic [NWP-1:0] en,
                                       output logic [NWP*INDEX-1:0] ad,
                                       output logic [NWP*WIDTH-1:0] da);
        for (int p = 0; p < NWP; p++) begin
            int off;
            off = cyc * NWP + p;
            en[p] = (off < size);
            ad[p*INDEX +: INDEX] = INDEX'(base + off);
            da[p*WIDTH +: WIDTH] = WIDTH'(SEQ + base + off);
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wrEn  = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            n_cmp++;
            if (wrEnRam !== 4'b0000) begin
                n_bad++; $display("FAIL reset_wren: got %b want 0000", wrEnRam);
            end
            n_cmp++;
            if (dropped !== 1'b0) begin
                n_bad++; $display("FAIL reset_dropped: got %b want 0", dropped);
            end
            n_cmp++;
            if (ready !== 1'b0) begin
                n_bad++; $display("FAIL reset_ready: got %b want 0", ready);
            end
        end
    endtask

    // Full INIT walk starting in the window after reset was applied.
    task automatic test_init_walk(input bit withDrops);
        logic [NWP-1:0]       en;
        logic [NWP*INDEX-1:0] ad;
        logic [NWP*WIDTH-1:0] da;
        logic [NWP-1:0]       w;
        for (int c = 0; c < DEPTH / NWP; c++) begin
            next_cycle();
            reset = 1'b0;
            w = withDrops ? 4'($urandom_range(0, 15)) : 4'b0000;
            if (withDrops && c == 2) w = 4'b0001;
            wrEn   = w;
            addrWr = 20'($urandom);
            dataWr = {$urandom, $urandom, $urandom, $urandom};
            #1;
            model_walk(c, 0, DEPTH, en, ad, da);
            n_cmp++;
            if (wrEnRam !== en) begin
                n_bad++; $display("FAIL init_wren c%0d: got %b want %b", c, wrEnRam, en);
            end
            n_cmp++;
            if (dropped !== (w != 4'b0000)) begin
                n_bad++; $display("FAIL init_dropped c%0d: got %b want %b", c, dropped, (w != 4'b0000));
            end
            n_cmp++;
            if (ready !== 1'b0) begin
                n_bad++; $display("FAIL init_ready c%0d: got %b want 0", c, ready);
            end
            for (int p = 0; p < NWP; p++) begin
                if (en[p]) begin
                    n_cmp++;
                    if ({addrRam[p*INDEX +: INDEX], dataRam[p*WIDTH +: WIDTH]} !==
                        {ad[p*INDEX +: INDEX], da[p*WIDTH +: WIDTH]}) begin
                        n_bad++;
                        $display("FAIL init_lane c%0d p%0d: got a=%0d d=%h want a=%0d d=%h", c, p,
                                 addrRam[p*INDEX +: INDEX], dataRam[p*WIDTH +: WIDTH],
                                 ad[p*INDEX +: INDEX], da[p*WIDTH +: WIDTH]);
                    end
                end
            end
        end
        next_cycle();
        wrEn = 4'b0000;
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++; $display("FAIL init_done_ready: got %b want 1", ready);
        end
    endtask

    task automatic test_passthrough();
        logic [NWP*INDEX-1:0] ea;
        logic [NWP*WIDTH-1:0] ed;
        next_cycle();
        wrEn   = 4'b0101;
        addrWr = '0;
        dataWr = '0;
        addrWr[0*INDEX +: INDEX] = 5'd3;
        addrWr[2*INDEX +: INDEX] = 5'd7;
        dataWr[0*WIDTH +: WIDTH] = 32'hA5A5A5A5;
        dataWr[2*WIDTH +: WIDTH] = 32'h5A5A5A5A;
        #1;
        n_cmp++;
        if (wrEnRam !== 4'b0101) begin
            n_bad++; $display("FAIL pass_dir_wren: got %b want 0101", wrEnRam);
        end
        n_cmp++;
        if ({addrRam[0 +: INDEX], addrRam[2*INDEX +: INDEX]} !== {5'd3, 5'd7}) begin
            n_bad++; $display("FAIL pass_dir_addr: got %0d/%0d want 3/7",
                              addrRam[0 +: INDEX], addrRam[2*INDEX +: INDEX]);
        end
        n_cmp++;
        if ({dataRam[0 +: WIDTH], dataRam[2*WIDTH +: WIDTH]} !== {32'hA5A5A5A5, 32'h5A5A5A5A}) begin
            n_bad++; $display("FAIL pass_dir_data: got %h/%h want a5a5a5a5/5a5a5a5a",
                              dataRam[0 +: WIDTH], dataRam[2*WIDTH +: WIDTH]);
        end
        n_cmp++;
        if (dropped !== 1'b0) begin
            n_bad++; $display("FAIL pass_dir_dropped: got %b want 0", dropped);
        end
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            wrEn   = 4'($urandom_range(0, 15));
            ea     = 20'($urandom);
            ed     = {$urandom, $urandom, $urandom, $urandom};
            addrWr = ea;
            dataWr = ed;
            #1;
            n_cmp++;
            if (wrEnRam !== wrEn || dropped !== 1'b0 || ready !== 1'b1) begin
                n_bad++; $display("FAIL pass_rand_ctl i%0d: got en=%b drop=%b rdy=%b want en=%b drop=0 rdy=1",
                                  i, wrEnRam, dropped, ready, wrEn);
            end
            for (int p = 0; p < NWP; p++) begin
                if (wrEn[p]) begin
                    n_cmp++;
                    if ({addrRam[p*INDEX +: INDEX], dataRam[p*WIDTH +: WIDTH]} !==
                        {ea[p*INDEX +: INDEX], ed[p*WIDTH +: WIDTH]}) begin
                        n_bad++; $display("FAIL pass_rand_lane i%0d p%0d: got a=%0d d=%h want a=%0d d=%h",
                                          i, p, addrRam[p*INDEX +: INDEX], dataRam[p*WIDTH +: WIDTH],
                                          ea[p*INDEX +: INDEX], ed[p*WIDTH +: WIDTH]);
                    end
                end
            end
        end
        next_cycle();
        wrEn = 4'b0000;
    endtask

    task automatic test_drop_in_init();
        reset = 1'b1;
        wrEn  = 4'b0000;
        #1;
        test_init_walk(1'b1);
    endtask

    task automatic test_reset_mid_init();
        logic [NWP-1:0]       en;
        logic [NWP*INDEX-1:0] ad;
        logic [NWP*WIDTH-1:0] da;
        next_cycle();
        reset = 1'b1;
        wrEn  = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            reset = 1'b0;
            #1;
            model_walk(c, 0, DEPTH, en, ad, da);
            n_cmp++;
            if (wrEnRam !== en || addrRam[0 +: INDEX] !== ad[0 +: INDEX]) begin
                n_bad++; $display("FAIL mid_pre c%0d: got en=%b a0=%0d want en=%b a0=%0d",
                                  c, wrEnRam, addrRam[0 +: INDEX], en, ad[0 +: INDEX]);
            end
        end
        next_cycle();
        reset = 1'b1;
        wrEn  = 4'b0011;
        #1;
        n_cmp++;
        if (wrEnRam !== 4'b0000 || dropped !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: got en=%b drop=%b want en=0000 drop=0", wrEnRam, dropped);
        end
        test_init_walk(1'b0);
    endtask

`ifdef RAM_PART_REINIT_EN
    // Ungate partitions 1 and 2 together; optionally re-gate partition 1 in
    // its first re-init cycle. Expected walk is listed as (part, cycle) pairs.
    task automatic run_reinit(input bit abortPart1);
        logic [NWP-1:0]       en;
        logic [NWP*INDEX-1:0] ad;
        logic [NWP*WIDTH-1:0] da;
        int parts[$];
        int cycs[$];
        int k;
        next_cycle();
        gated = 4'b0110;
        next_cycle();
        next_cycle();
        next_cycle();
        gated = 4'b0000;
        #1;
        k = 0;
        while (ready === 1'b1 && k < 6) begin
            next_cycle();
            k++;
        end
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++; $display("FAIL reinit_start: got ready=%b want 0 within 6 cycles", ready);
            return;
        end
        if (abortPart1) begin
            parts = '{1, 2, 2};
            cycs  = '{0, 0, 1};
        end else begin
            parts = '{1, 1, 2, 2};
            cycs  = '{0, 1, 0, 1};
        end
        for (int i = 0; i < parts.size(); i++) begin
            if (i > 0) next_cycle();
            model_walk(cycs[i], parts[i] * PDEP, PDEP, en, ad, da);
            n_cmp++;
            if (ready !== 1'b0 || wrEnRam !== en) begin
                n_bad++; $display("FAIL reinit_ctl s%0d: got rdy=%b en=%b want rdy=0 en=%b",
                                  i, ready, wrEnRam, en);
            end
            for (int p = 0; p < NWP; p++) begin
                n_cmp++;
                if ({addrRam[p*INDEX +: INDEX], dataRam[p*WIDTH +: WIDTH]} !==
                    {ad[p*INDEX +: INDEX], da[p*WIDTH +: WIDTH]}) begin
                    n_bad++; $display("FAIL reinit_lane s%0d p%0d: got a=%0d d=%h want a=%0d d=%h",
                                      i, p, addrRam[p*INDEX +: INDEX], dataRam[p*WIDTH +: WIDTH],
                                      ad[p*INDEX +: INDEX], da[p*WIDTH +: WIDTH]);
                end
            end
            if (abortPart1 && i == 0) begin
                gated = 4'b0010;
                #1;
            end
        end
        next_cycle();
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++; $display("FAIL reinit_done: got ready=%b want 1", ready);
        end
    endtask
`else
    // Same gating stimulus without the feature: nothing may happen.
    task automatic run_reinit(input bit abortPart1);
        next_cycle();
        gated = 4'b0110;
        next_cycle();
        next_cycle();
        next_cycle();
        gated = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            if (abortPart1 && i == 2) gated = 4'b0010;
            #1;
            n_cmp++;
            if (ready !== 1'b1 || wrEnRam !== 4'b0000) begin
                n_bad++; $display("FAIL noreinit i%0d: got rdy=%b en=%b want rdy=1 en=0000",
                                  i, ready, wrEnRam);
            end
        end
    endtask
`endif

    task automatic test_reinit();
        run_reinit(1'b0);
    endtask

    task automatic test_reinit_abort();
        run_reinit(1'b1);
    endtask

    initial begin
        reset  = 1'b1;
        gated  = 4'b0000;
        wrEn   = 4'b0000;
        addrWr = '0;
        dataWr = '0;
        test_reset();
        test_init_walk(1'b0);
        test_passthrough();
        test_drop_in_init();
        test_reset_mid_init();
        test_reinit();
        test_reinit_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
